// File: rtl/reg_ops_pkg.sv
// reg_ops_pkg: shared types and helpers for the reg_ops_seq register unit.
//   op_e        - the eight register operation codes
//   state_e     - sequencer states (IDLE, RUN)
//   amt_width() - width of the shift-amount field for a given register width
//   is_shift_op - true for the five shift/rotate codes
package reg_ops_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_CPL  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_ASR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_ROR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  // One extra bit beyond log2(width) so that an amount equal to the full
  // width (and anything larger, which gets clamped) is representable.
  function automatic int amt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/reg_ops_seq_if.sv
// reg_ops_seq_if: command/result bundle between a control FSM (master) and
// the reg_ops_seq register unit (slave).
//   start - command strobe, sampled only while the unit is idle
//   op    - operation code (reg_ops_pkg::op_e encoding)
//   amt   - shift/rotate amount, clamped to WIDTH by the unit
//   din   - load data
//   sin   - serial fill bit for SHL/SHR, sampled on every shift edge
//   q     - register contents
//   sout  - last bit shifted or rotated out
//   busy  - multi-cycle operation in progress
//   done  - one-cycle completion pulse
interface reg_ops_seq_if #(
  parameter int WIDTH = 4
);
  import reg_ops_pkg::*;

  localparam int AMT_W = amt_width(WIDTH);

  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, din, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  start, op, amt, din, sin,
    output q, sout, busy, done
  );

endinterface

// File: rtl/reg_ops_step.sv
// reg_ops_step: combinational single-bit shift/rotate step.
//   q       - current register value
//   op      - shift/rotate code (non-shift codes pass q through)
//   sin     - fill bit for SHL/SHR
//   next_q  - register value after one step
//   out_bit - bit that leaves the register on this step
module reg_ops_step
  import reg_ops_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             sin,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  // up_q moves every bit one place toward the MSB, dn_q one place toward
  // the LSB; the vacated end bit of each is chosen by the fill logic below.
  logic [WIDTH-1:0] up_q;
  logic [WIDTH-1:0] dn_q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_move
      assign up_q[gi+1] = q[gi];
      assign dn_q[gi]   = q[gi+1];
    end
  endgenerate

  assign up_q[0]       = (op == OP_ROL) ? q[WIDTH-1] : sin;
  assign dn_q[WIDTH-1] = (op == OP_ASR) ? q[WIDTH-1] :
                         (op == OP_ROR) ? q[0]       : sin;

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL, OP_ROL: begin
        next_q  = up_q;
        out_bit = q[WIDTH-1];
      end
      OP_SHR, OP_ASR, OP_ROR: begin
        next_q  = dn_q;
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_ops_seq.sv
// reg_ops_seq: WIDTH-bit register with load, complement, shift and rotate
// operations. Shifts/rotates by k (k = min(amt, WIDTH)) run one bit per
// clock under a start/busy/done handshake; everything else completes on
// the accepting edge.
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears all state
//   bus   - reg_ops_seq_if slave: start/op/amt/din/sin in, q/sout/busy/done out
module reg_ops_seq #(
  parameter int WIDTH = reg_ops_pkg::DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          reset,
  reg_ops_seq_if.slave bus
);
  import reg_ops_pkg::*;

  localparam int               AMT_W     = amt_width(WIDTH);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] ONE_AMT   = AMT_W'(1);

  state_e           state_reg;
  op_e              op_reg;
  logic [AMT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] q_reg;
  logic             sout_reg;
  logic             busy_reg;
  logic             done_reg;

  op_e              cmd_op;
  logic [AMT_W-1:0] k_next;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign cmd_op = op_e'(bus.op);
  // Rotates are clamped too, so rotate-by-WIDTH is a full lap.
  assign k_next = (bus.amt > WIDTH_AMT) ? WIDTH_AMT : bus.amt;

  // The step always works from the latched op; sin is live on each edge.
  reg_ops_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (q_reg),
    .op      (op_reg),
    .sin     (bus.sin),
    .next_q  (step_q),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_NOP;
      cnt_reg   <= '0;
      q_reg     <= '0;
      sout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            op_reg <= cmd_op;
            if (is_shift_op(cmd_op) && (k_next != '0)) begin
              state_reg <= ST_RUN;
              cnt_reg   <= k_next;
              busy_reg  <= 1'b1;
            end else begin
              // Single-cycle command, including a zero-length shift.
              done_reg <= 1'b1;
              if (cmd_op == OP_LOAD) begin
                q_reg <= bus.din;
              end else if (cmd_op == OP_CPL) begin
                q_reg <= ~q_reg;
              end
            end
          end
        end
        ST_RUN: begin
          q_reg    <= step_q;
          sout_reg <= step_bit;
          cnt_reg  <= cnt_reg - ONE_AMT;
          if (cnt_reg == ONE_AMT) begin
            // Final step: done rises as busy falls, so a new start can be
            // taken on the very next edge.
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_reg;
  assign bus.sout = sout_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_reg_ops_seq.sv
// tb_reg_ops_seq: self-checking bench for reg_ops_seq at WIDTH=8.
// A command-level model predicts q/sout/busy/done after every clock edge and
// a single compare process checks the DUT against it on every falling edge.
// Directed scenarios add literal expectations; a randomized phase follows.
module tb_reg_ops_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  reg_ops_seq_if #(.WIDTH(W)) bus ();

  reg_ops_seq #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t       exp_fifo[$];
  exp_t       cmp_e;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] m_q;
  logic       m_sout;
  logic [7:0] tr_q    [0:16];
  logic       tr_sout [0:16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  // Compare process: one expectation per clock edge since the first reset.
  always @(negedge clk) begin
    if (exp_fifo.size() > 0) begin
      cmp_e = exp_fifo.pop_front();
      chk("cyc_q",    32'(bus.q),    32'(cmp_e.q));
      chk("cyc_sout", 32'(bus.sout), 32'(cmp_e.sout));
      chk("cyc_busy", 32'(bus.busy), 32'(cmp_e.busy));
      chk("cyc_done", 32'(bus.done), 32'(cmp_e.done));
    end
  end

  // One shift/rotate step by arithmetic: returns {bit_out, new_value}.
  function automatic logic [8:0] model_step(input logic [2:0] op, input logic [7:0] v, input logic s);
    int x, si, nq, ob;
    x  = int'(v);
    si = s ? 1 : 0;
    case (op)
      3'd3:    begin nq = (x * 2 + si) % 256;         ob = x / 128; end
      3'd4:    begin nq = x / 2 + si * 128;           ob = x % 2;   end
      3'd5:    begin nq = x / 2 + (x / 128) * 128;    ob = x % 2;   end
      3'd6:    begin nq = (x * 2) % 256 + x / 128;    ob = x / 128; end
      default: begin nq = x / 2 + (x % 2) * 128;      ob = x % 2;   end
    endcase
    return {ob[0], nq[7:0]};
  endfunction

  // Inputs are set at a falling edge; this advances one rising edge and
  // queues what the outputs must be afterwards.
  task automatic edge_push(input logic [7:0] q, input logic so, input logic b, input logic d);
    exp_t e;
    e.q = q; e.sout = so; e.busy = b; e.done = d;
    @(posedge clk);
    exp_fifo.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) edge_push(m_q, m_sout, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 3'($urandom);
    bus.amt   = 4'($urandom);
    bus.din   = 8'($urandom);
    bus.sin   = 1'($urandom);
    m_q       = 8'h00;
    m_sout    = 1'b0;
    for (int i = 0; i < n; i++) edge_push(8'h00, 1'b0, 1'b0, 1'b0);
    reset     = 1'b0;
    bus.start = 1'b0;
    $display("reset %0d cycles -> q=%02h", n, bus.q);
  endtask

  // Issue one command. abort_at>0 resets after that many steps;
  // sin_force<0 means random fill bits; noise_load drives LOAD 0xFF
  // with start high throughout the run.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din,
                         input int abort_at, input int sin_force, input bit noise_load);
    int         k;
    bit         multi;
    logic       s;
    logic [8:0] r;
    k     = (int'(amt) > W) ? W : int'(amt);
    multi = (op >= 3'd3) && (k > 0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.amt   = amt;
    bus.din   = din;
    bus.sin   = 1'($urandom);
    if (!multi) begin
      if (op == 3'd1) m_q = din;
      else if (op == 3'd2) m_q = ~m_q;
      edge_push(m_q, m_sout, 1'b0, 1'b1);
    end else begin
      edge_push(m_q, m_sout, 1'b1, 1'b0);
      for (int i = 1; i <= k; i++) begin
        if (abort_at != 0 && i == abort_at + 1) begin
          reset     = 1'b1;
          bus.start = 1'($urandom);
          m_q       = 8'h00;
          m_sout    = 1'b0;
          edge_push(8'h00, 1'b0, 1'b0, 1'b0);
          reset     = 1'b0;
          bus.start = 1'b0;
          $display("cmd op=%0d amt=%0d din=%02h aborted after %0d steps -> q=%02h",
                   op, amt, din, abort_at, bus.q);
          return;
        end
        s = (sin_force < 0) ? 1'($urandom) : sin_force[0];
        bus.sin = s;
        if (noise_load) begin
          bus.start = 1'b1;
          bus.op    = 3'd1;
          bus.din   = 8'hFF;
        end else begin
          bus.start = 1'($urandom);
          bus.op    = 3'($urandom);
          bus.amt   = 4'($urandom);
          bus.din   = 8'($urandom);
        end
        r          = model_step(op, m_q, s);
        m_q        = r[7:0];
        m_sout     = r[8];
        tr_q[i]    = m_q;
        tr_sout[i] = m_sout;
        edge_push(m_q, m_sout, 1'(i < k), 1'(i == k));
      end
    end
    bus.start = 1'b0;
    $display("cmd op=%0d amt=%0d din=%02h -> q=%02h sout=%0b done=%0b",
             op, amt, din, bus.q, bus.sout, bus.done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.amt   = 4'd0;
    bus.din   = 8'h00;
    bus.sin   = 1'b0;
    m_q       = 8'h00;
    m_sout    = 1'b0;
    @(negedge clk);

    // 1: reset with random inputs
    do_reset(2);
    chk("rst_q",    32'(bus.q),    32'h00);
    chk("rst_sout", 32'(bus.sout), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);

    // 2: LOAD then CPL
    run_cmd(3'd1, 4'd0, 8'hA5, 0, -1, 1'b0);
    chk("load_q",    32'(bus.q),    32'hA5);
    chk("load_done", 32'(bus.done), 32'h1);
    run_cmd(3'd2, 4'd0, 8'h00, 0, -1, 1'b0);
    chk("cpl_q", 32'(bus.q), 32'h5A);

    // 3: SHL by 3 with sin=1 from 0x81
    run_cmd(3'd1, 4'd0, 8'h81, 0, -1, 1'b0);
    run_cmd(3'd3, 4'd3, 8'h00, 0, 1, 1'b0);
    chk("shl_step1", 32'(tr_q[1]), 32'h03);
    chk("shl_step2", 32'(tr_q[2]), 32'h07);
    chk("shl_step3", 32'(tr_q[3]), 32'h0F);
    chk("shl_sout1", 32'(tr_sout[1]), 32'h1);
    chk("shl_sout2", 32'(tr_sout[2]), 32'h0);
    chk("shl_q",     32'(bus.q),    32'h0F);
    chk("shl_done",  32'(bus.done), 32'h1);
    chk("shl_busy",  32'(bus.busy), 32'h0);

    // 4: ASR by 2 from 0x90, then ROL by 1
    run_cmd(3'd1, 4'd0, 8'h90, 0, -1, 1'b0);
    run_cmd(3'd5, 4'd2, 8'h00, 0, -1, 1'b0);
    chk("asr_step1", 32'(tr_q[1]), 32'hC8);
    chk("asr_q",     32'(bus.q),    32'hE4);
    chk("asr_sout",  32'(bus.sout), 32'h0);
    run_cmd(3'd6, 4'd1, 8'h00, 0, -1, 1'b0);
    chk("rol_q",    32'(bus.q),    32'hC9);
    chk("rol_sout", 32'(bus.sout), 32'h1);

    // 5: ROR by 12 clamps to a full lap; LOAD 0xFF mid-run is ignored
    run_cmd(3'd1, 4'd0, 8'h3C, 0, -1, 1'b0);
    run_cmd(3'd7, 4'd12, 8'h00, 0, -1, 1'b1);
    chk("ror_step1", 32'(tr_q[1]), 32'h1E);
    chk("ror_q",     32'(bus.q),    32'h3C);
    chk("ror_done",  32'(bus.done), 32'h1);

    // 6: reset after the 2nd SHR step, then zero-amount shifts
    run_cmd(3'd1, 4'd0, 8'hF0, 0, -1, 1'b0);
    run_cmd(3'd4, 4'd5, 8'h00, 2, 0, 1'b0);
    chk("abort_q",    32'(bus.q),    32'h00);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    idle(3);
    chk("abort_nodone", 32'(bus.done), 32'h0);
    run_cmd(3'd3, 4'd0, 8'h00, 0, -1, 1'b0);
    chk("shl0_q",    32'(bus.q),    32'h00);
    chk("shl0_done", 32'(bus.done), 32'h1);
    run_cmd(3'd1, 4'd0, 8'h3C, 0, -1, 1'b0);
    run_cmd(3'd3, 4'd0, 8'h00, 0, -1, 1'b0);
    chk("shl0b_q", 32'(bus.q), 32'h3C);

    // Randomized commands, back-to-back or with gaps
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) do_reset(1);
      run_cmd(3'($urandom), 4'($urandom), 8'($urandom),
              ($urandom_range(0, 14) == 0) ? $urandom_range(1, 3) : 0, -1, 1'b0);
    end

    idle(2);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
